// File: rtl/fibonacci_pkg.sv
// fibonacci_pkg: shared widths, FSM states and control register offsets for the Fibonacci engine.
package fibonacci_pkg;
  localparam int CLOCK_WIDTH = 6;
  localparam int VAL_WIDTH = 30;
  localparam int IO_PADS = 38;
  localparam int IO_BASE = 8;
  localparam logic [7:0] CTRL_SWITCH = 8'h00;
  localparam logic [7:0] CTRL_CLOCK_OP = 8'h04;
  localparam logic [7:0] CTRL_BUF_IO = 8'h14;
  typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/fibonacci_core_tick_div.sv
// fib_tick_div: divides wb_clk_i by clock_op while running; a clock_op change restarts the period.
module fib_tick_div #(
  parameter int CLOCK_WIDTH = fibonacci_pkg::CLOCK_WIDTH
) (
  input  logic                   wb_clk_i,
  input  logic                   reset,
  input  logic                   run,
  input  logic [CLOCK_WIDTH-1:0] clock_op,
  output logic                   tick
);
  logic [CLOCK_WIDTH-1:0] div_cnt;
  logic [CLOCK_WIDTH-1:0] op_q;
  logic op_chg;
  assign op_chg = clock_op != op_q;
  assign tick = run && !op_chg && clock_op != '0 && div_cnt == clock_op - 1'b1;
  always_ff @(posedge wb_clk_i) begin
    if (reset) begin
      div_cnt <= '0;
      op_q <= '0;
    end else begin
      op_q <= clock_op;
      div_cnt <= (!run || op_chg || tick) ? '0 : div_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/fibonacci_core.sv
// fibonacci_core: advances a Fibonacci sequence once per divided tick and drives the term onto the pads.
module fibonacci_core #(
  parameter int CLOCK_WIDTH = fibonacci_pkg::CLOCK_WIDTH,
  parameter int VAL_WIDTH = fibonacci_pkg::VAL_WIDTH,
  parameter int IO_PADS = fibonacci_pkg::IO_PADS,
  parameter int IO_BASE = fibonacci_pkg::IO_BASE
) (
  input  logic                   wb_clk_i,
  input  logic                   reset,
  input  logic [CLOCK_WIDTH-1:0] clock_op,
  input  logic                   switch_in,
  output logic [IO_PADS-1:0]     io_out,
  output logic [IO_PADS-1:0]     io_oeb,
  output logic [VAL_WIDTH-1:0]   fib_val,
  output logic                   tick_o,
  output logic                   wrap_o
);
  import fibonacci_pkg::*;
  state_t state, state_nxt;
  logic [VAL_WIDTH-1:0] a, b;
  logic [VAL_WIDTH:0] sum;
  logic tick;
  fib_tick_div #(.CLOCK_WIDTH(CLOCK_WIDTH)) u_div (
    .wb_clk_i(wb_clk_i),
    .reset(reset),
    .run(state == RUN),
    .clock_op(clock_op),
    .tick(tick)
  );
  always_comb begin
    state_nxt = state;
    sum = {1'b0, a} + {1'b0, b};
    state_nxt = (switch_in && clock_op != '0) ? RUN : IDLE;
  end
  always_ff @(posedge wb_clk_i) begin
    if (reset) state <= IDLE;
    else state <= state_nxt;
  end
  // a/b survive RUN->IDLE so a later RUN resumes from the held term
  always_ff @(posedge wb_clk_i) begin
    if (reset) begin
      a <= '0;
      b <= VAL_WIDTH'(1);
      tick_o <= 1'b0;
      wrap_o <= 1'b0;
    end else begin
      tick_o <= tick;
      wrap_o <= tick && sum[VAL_WIDTH];
      if (tick) begin
        a <= sum[VAL_WIDTH] ? '0 : b;
        b <= sum[VAL_WIDTH] ? VAL_WIDTH'(1) : sum[VAL_WIDTH-1:0];
      end
    end
  end
  assign fib_val = a;
  assign io_out = {a, {IO_BASE{1'b0}}};
  assign io_oeb = {{VAL_WIDTH{1'b0}}, {IO_BASE{1'b1}}};
endmodule

// File: tb/tb_fibonacci_core.sv
// tb_fibonacci_core: random and directed stimulus checked against a cycle-level behavioural model.
module tb_fibonacci_core;
  logic wb_clk_i = 0;
  logic reset = 1;
  logic [5:0] clock_op = 6'd1;
  logic switch_in = 1;
  logic [37:0] io_out, io_oeb;
  logic [29:0] fib_val;
  logic tick_o, wrap_o;
  int checks = 0;
  int failures = 0;
  fibonacci_core dut (
    .wb_clk_i(wb_clk_i),
    .reset(reset),
    .clock_op(clock_op),
    .switch_in(switch_in),
    .io_out(io_out),
    .io_oeb(io_oeb),
    .fib_val(fib_val),
    .tick_o(tick_o),
    .wrap_o(wrap_o)
  );
  always #5 wb_clk_i = ~wb_clk_i;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Behavioural model: running flag, cycles into the current tick period, and the two live terms.
  bit m_run, started, e_tick, e_wrap, fire;
  int m_phase, m_prev;
  longint m_a = 0, m_b = 1, s;
  always @(posedge wb_clk_i) begin
    started = 1;
    e_tick = 0;
    e_wrap = 0;
    if (reset) begin
      m_run = 0; m_phase = 0; m_prev = 0; m_a = 0; m_b = 1;
    end else begin
      fire = m_run && int'(clock_op) == m_prev && clock_op != 0 && m_phase + 1 == int'(clock_op);
      m_phase = (!m_run || int'(clock_op) != m_prev || fire) ? 0 : m_phase + 1;
      if (fire) begin
        e_tick = 1;
        s = m_a + m_b;
        if (s >= (64'd1 << 30)) begin
          e_wrap = 1; m_a = 0; m_b = 1;
        end else begin
          m_a = m_b; m_b = s;
        end
      end
      m_prev = int'(clock_op);
      m_run = switch_in && clock_op != 0;
    end
  end
  always @(negedge wb_clk_i) begin
    if (started) begin
      chk("tick_o", 64'(tick_o), 64'(e_tick));
      chk("wrap_o", 64'(wrap_o), 64'(e_wrap));
      chk("fib_val", 64'(fib_val), 64'(m_a[29:0]));
      chk("io_out", 64'(io_out), 64'({m_a[29:0], 8'h00}));
      chk("io_oeb", 64'(io_oeb), 64'h00_0000_00FF);
    end
  end
  task automatic wait_ticks(input int n, input string nm);
    int c = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge wb_clk_i);
      if (tick_o) c++;
      if (c == n) return;
    end
    chk({nm, "_timeout"}, 64'(c), 64'(n));
  endtask
  task automatic gap(output int g);
    g = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge wb_clk_i);
      g++;
      if (tick_o) return;
    end
  endtask
  int g, n;
  initial begin
    repeat (3) @(negedge wb_clk_i);
    chk("rst_fib", 64'(fib_val), 0);
    chk("rst_tick", 64'(tick_o), 0);
    chk("rst_oeb", 64'(io_oeb), 64'h00_0000_00FF);
    reset = 0;
    wait_ticks(6, "t1");
    chk("sixth_term", 64'(fib_val), 8);
    chk("pads_low", 64'(io_out[7:0]), 0);
    clock_op = 6'd4;
    wait_ticks(1, "t2a");
    gap(g);
    chk("gap4", 64'(g), 4);
    @(negedge wb_clk_i);
    clock_op = 6'd2;
    wait_ticks(1, "t2b");
    gap(g);
    chk("gap2", 64'(g), 2);
    reset = 1;
    clock_op = 6'd1;
    @(negedge wb_clk_i);
    reset = 0;
    wait_ticks(11, "t3");
    switch_in = 0;
    repeat (20) @(negedge wb_clk_i);
    chk("held_144", 64'(fib_val), 144);
    switch_in = 1;
    wait_ticks(1, "t3b");
    chk("resume_233", 64'(fib_val), 233);
    clock_op = 6'd0;
    repeat (10) @(negedge wb_clk_i);
    chk("halt_233", 64'(fib_val), 233);
    clock_op = 6'd3;
    wait_ticks(1, "t4");
    gap(g);
    chk("gap3", 64'(g), 3);
    chk("term_610", 64'(fib_val), 610);
    reset = 1;
    clock_op = 6'd1;
    @(negedge wb_clk_i);
    reset = 0;
    n = 0;
    for (int i = 0; i < 200 && !wrap_o; i++) begin
      @(negedge wb_clk_i);
      if (tick_o) n++;
    end
    chk("wrap_seen", 64'(wrap_o), 1);
    chk("wrap_tick_no", 64'(n), 44);
    chk("wrap_fib", 64'(fib_val), 0);
    wait_ticks(1, "t5");
    chk("after_wrap", 64'(fib_val), 1);
    clock_op = 6'd4;
    wait_ticks(1, "t6");
    repeat (3) @(negedge wb_clk_i);
    reset = 1;
    @(negedge wb_clk_i);
    chk("rst_drop_tick", 64'(tick_o), 0);
    chk("rst_drop_fib", 64'(fib_val), 0);
    reset = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge wb_clk_i);
      if ($urandom_range(0, 39) == 0) switch_in = ~switch_in;
      if ($urandom_range(0, 59) == 0) clock_op = 6'($urandom_range(0, 5));
      if ($urandom_range(0, 199) == 0) clock_op = 6'($urandom_range(0, 63));
      reset = $urandom_range(0, 499) == 0;
    end
    @(negedge wb_clk_i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
